// File: rtl/memory_loader_pkg.sv
// Shared definitions for the memory loader: FSM encoding, parameter defaults
// and a word-packing helper.
package loader_defs;

    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        IDLE_HI = 2'd1,
        WRITE   = 2'd2,
        ERROR   = 2'd3
    } state_t;

    // High half-word goes in bits [31:16], the earlier-entered half in [15:0].
    function automatic logic [31:0] pack_word(input logic [15:0] hi, input logic [15:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/memory_loader_edge.sv
// Single-cycle press pulse from a debounced button level. The previous sample
// resets high so a button held through reset must be released first.
module rising_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic press_o
);

    logic prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign press_o = level_i & ~prev_q;

endmodule

// File: rtl/memory_loader.sv
// Switch-driven RAM loader: two half-word presses build a 32-bit word that is
// written at the current address, which then auto-increments.
module memory_loader
    import loader_defs::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       sw_data,
    input  logic              sw_addr_load,
    input  logic              enter,
    input  logic              mem_MFC,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_dataIn,
    output logic              mem_write,
    output logic              busy,
    output logic              half_sel,
    output logic              error,
    output logic [1:0]        dbg_state
);

    // Handshake: mem_write rises with mem_address/mem_dataIn valid and holds
    // them stable until mem_MFC is sampled high (or the timeout expires).
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [15:0]       lo_q, lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              press;

    rising_edge_detect u_press (
        .clk     (clk),
        .reset   (reset),
        .level_i (enter),
        .press_o (press)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE_LO;
            addr_q  <= '0;
            data_q  <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE_LO: begin
                if (press) begin
                    if (sw_addr_load) begin
                        addr_d = ADDR_W'(sw_data);
                        lo_d   = '0;
                    end else begin
                        lo_d    = sw_data;
                        state_d = IDLE_HI;
                    end
                end
            end
            IDLE_HI: begin
                if (press) begin
                    if (sw_addr_load) begin
                        addr_d  = ADDR_W'(sw_data);
                        lo_d    = '0;
                        state_d = IDLE_LO;
                    end else begin
                        data_d  = pack_word(sw_data, lo_q);
                        cnt_d   = '0;
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                // An acknowledge on the expiry edge still counts as success.
                if (mem_MFC) begin
                    addr_d  = addr_q + 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ERROR: begin
                if (press) begin
                    err_d   = 1'b0;
                    state_d = IDLE_LO;
                end
            end
            default: state_d = IDLE_LO;
        endcase
    end

    assign mem_address = addr_q;
    assign mem_dataIn  = data_q;
    assign mem_write   = (state_q == WRITE);
    assign busy        = (state_q == WRITE);
    assign half_sel    = (state_q == IDLE_HI);
    assign error       = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_memory_loader.sv
// Directed self-checking bench for memory_loader: basic write, wrap, timeout,
// ignored presses and reset in mid-operation.
module tb_memory_loader;
    import loader_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] sw_data;
    logic        sw_addr_load;
    logic        enter;
    logic        mem_MFC;
    logic [7:0]  mem_address;
    logic [31:0] mem_dataIn;
    logic        mem_write;
    logic        busy;
    logic        half_sel;
    logic        error;
    logic [1:0]  dbg_state;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int hi_cycles;

    memory_loader #(.ADDR_W(8), .TIMEOUT(255)) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_data      (sw_data),
        .sw_addr_load (sw_addr_load),
        .enter        (enter),
        .mem_MFC      (mem_MFC),
        .mem_address  (mem_address),
        .mem_dataIn   (mem_dataIn),
        .mem_write    (mem_write),
        .busy         (busy),
        .half_sel     (half_sel),
        .error        (error),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press lands on the next edge; leaves enter low so the following edge releases.
    task automatic press_edge(input logic [15:0] d, input logic addr_sel);
        sw_data      = d;
        sw_addr_load = addr_sel;
        enter        = 1'b1;
        tick();
        enter        = 1'b0;
    endtask

    task automatic press(input logic [15:0] d, input logic addr_sel);
        press_edge(d, addr_sel);
        tick();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_addr"},  32'(mem_address), 32'h0);
        chk({tag, "_data"},  mem_dataIn,       32'h0);
        chk({tag, "_write"}, 32'(mem_write),   32'h0);
        chk({tag, "_busy"},  32'(busy),        32'h0);
        chk({tag, "_half"},  32'(half_sel),    32'h0);
        chk({tag, "_err"},   32'(error),       32'h0);
        chk({tag, "_state"}, 32'(dbg_state),   32'(IDLE_LO));
    endtask

    initial begin
        reset = 1'b1; sw_data = '0; sw_addr_load = 1'b0; enter = 1'b0; mem_MFC = 1'b0;
        tick(); tick();
        chk_reset_values("rst");
        reset = 1'b0;
        tick();

        // Basic write: 0x1234 then 0xABCD, MFC three cycles after the write starts.
        press(16'h1234, 1'b0);
        chk("basic_half_sel", 32'(half_sel), 32'h1);
        press_edge(16'hABCD, 1'b0);
        chk("basic_write", 32'(mem_write), 32'h1);
        chk("basic_busy", 32'(busy), 32'h1);
        chk("basic_addr", 32'(mem_address), 32'h00);
        chk("basic_data", mem_dataIn, 32'hABCD1234);
        hi_cycles = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_write) hi_cycles++;
        end
        mem_MFC = 1'b1;
        tick();
        if (mem_write) hi_cycles++;
        mem_MFC = 1'b0;
        chk("basic_hi_cycles", 32'(hi_cycles), 32'd4);
        chk("basic_write_off", 32'(mem_write), 32'h0);
        chk("basic_busy_off", 32'(busy), 32'h0);
        chk("basic_addr_inc", 32'(mem_address), 32'h01);
        chk("basic_half_sel0", 32'(half_sel), 32'h0);

        // Address wrap at 0xFF, with presses during WRITE ignored.
        press(16'h00FF, 1'b1);
        chk("wrap_addr_load", 32'(mem_address), 32'hFF);
        press(16'h0001, 1'b0);
        press(16'h0002, 1'b0);
        chk("wrap_data", mem_dataIn, 32'h00020001);
        chk("wrap_addr", 32'(mem_address), 32'hFF);
        press(16'h0055, 1'b1);
        press(16'h9999, 1'b0);
        chk("ign_addr", 32'(mem_address), 32'hFF);
        chk("ign_data", mem_dataIn, 32'h00020001);
        chk("ign_state", 32'(dbg_state), 32'(WRITE));
        mem_MFC = 1'b1;
        tick();
        mem_MFC = 1'b0;
        chk("wrap_addr0", 32'(mem_address), 32'h00);
        chk("wrap_state", 32'(dbg_state), 32'(IDLE_LO));

        // Timeout with MFC held low.
        press(16'h0010, 1'b1);
        press(16'h1111, 1'b0);
        press_edge(16'h2222, 1'b0);
        for (int i = 0; i < 254; i++) tick();
        chk("to_still_write", 32'(mem_write), 32'h1);
        chk("to_no_err_yet", 32'(error), 32'h0);
        tick();
        chk("to_write_off", 32'(mem_write), 32'h0);
        chk("to_busy_off", 32'(busy), 32'h0);
        chk("to_err", 32'(error), 32'h1);
        chk("to_addr", 32'(mem_address), 32'h10);
        chk("to_state", 32'(dbg_state), 32'(ERROR));
        mem_MFC = 1'b1;
        tick();
        mem_MFC = 1'b0;
        chk("err_mfc_addr", 32'(mem_address), 32'h10);
        chk("err_mfc_state", 32'(dbg_state), 32'(ERROR));
        press(16'h7777, 1'b0);
        chk("err_clear", 32'(error), 32'h0);
        chk("err_idle_lo", 32'(dbg_state), 32'(IDLE_LO));
        chk("err_press_discard", 32'(half_sel), 32'h0);

        // MFC on the expiry edge counts as success.
        press(16'h3333, 1'b0);
        press_edge(16'h4444, 1'b0);
        for (int i = 0; i < 254; i++) tick();
        mem_MFC = 1'b1;
        tick();
        mem_MFC = 1'b0;
        chk("edge_err", 32'(error), 32'h0);
        chk("edge_addr", 32'(mem_address), 32'h11);
        chk("edge_state", 32'(dbg_state), 32'(IDLE_LO));

        // Reset in IDLE_HI.
        press(16'h5555, 1'b0);
        chk("rhi_half_sel", 32'(half_sel), 32'h1);
        reset = 1'b1;
        tick();
        chk_reset_values("rhi");
        reset = 1'b0;
        tick();

        // Reset during WRITE, with enter held through reset release.
        press(16'hAAAA, 1'b0);
        press_edge(16'hBBBB, 1'b0);
        chk("rwr_in_write", 32'(mem_write), 32'h1);
        tick();
        reset = 1'b1;
        enter = 1'b1;
        tick();
        chk_reset_values("rwr");
        reset = 1'b0;
        tick();
        tick();
        chk("held_no_press_half", 32'(half_sel), 32'h0);
        chk("held_no_press_state", 32'(dbg_state), 32'(IDLE_LO));
        enter = 1'b0;
        tick();

        // Next word after reset lands at address 0.
        press(16'h0C0C, 1'b0);
        press_edge(16'h0D0D, 1'b0);
        chk("post_rst_addr", 32'(mem_address), 32'h00);
        chk("post_rst_data", mem_dataIn, 32'h0D0D0C0C);
        mem_MFC = 1'b1;
        tick();
        mem_MFC = 1'b0;
        chk("post_rst_inc", 32'(mem_address), 32'h01);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
